// File: rtl/trs_pipe.sv
// Two-stage, multi-channel truncate/round/saturate pipeline with a shared
// valid/ready handshake and a sticky saturation-event counter.
module trs_pipe #(
    parameter int IN_WIDTH      = 36,
    parameter int OUT_WIDTH     = 16,
    parameter int TRUNC         = 18,
    parameter int NUM_CH        = 2,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    rnd_mode,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [NUM_CH*IN_WIDTH-1:0]    s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [NUM_CH*OUT_WIDTH-1:0]   m_data,
    output logic [NUM_CH-1:0]             m_sat,
    output logic [SAT_CNT_WIDTH-1:0]      sat_cnt,
    input  logic                          sat_cnt_clr
);

    localparam int TW = IN_WIDTH - TRUNC;
    localparam int PW = $clog2(NUM_CH + 1);
    localparam int CW = SAT_CNT_WIDTH + PW + 1;
    localparam logic [CW-1:0] CNT_MAX = {{(CW-SAT_CNT_WIDTH){1'b0}}, {SAT_CNT_WIDTH{1'b1}}};

    logic en;
    logic s1_valid_reg;
    logic m_valid_reg;

    assign en      = ~m_valid_reg | m_ready;
    assign s_ready = en;
    assign m_valid = m_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [IN_WIDTH-1:0]  din;
            logic [TW:0]          t;
            logic                 g;
            logic                 s;
            logic                 r;
            logic [TW:0]          y_next;
            logic [TW:0]          y_reg;
            logic                 ovf;
            logic [OUT_WIDTH-1:0] dout_next;
            logic                 sat_next;
            logic [OUT_WIDTH-1:0] dout_reg;
            logic                 sat_reg;

            assign din = s_data[gi*IN_WIDTH +: IN_WIDTH];
            assign t   = {din[IN_WIDTH-1], din[IN_WIDTH-1:TRUNC]};
            assign g   = din[TRUNC-1];

            if (TRUNC > 1) begin : g_sticky
                assign s = |din[TRUNC-2:0];
            end else begin : g_nosticky
                assign s = 1'b0;
            end

            always_comb begin
                r = 1'b0;
                case (rnd_mode)
                    2'd0:    r = 1'b0;
                    2'd1:    r = g;
                    2'd2:    r = g & (s | t[0]);
                    default: r = g & (~din[IN_WIDTH-1] | s);
                endcase
            end

            // One headroom bit above the truncated field means +r cannot wrap.
            assign y_next = t + {{TW{1'b0}}, r};

            // Out of range whenever the bits above the output sign are not a pure sign extension.
            assign ovf = ~((&y_reg[TW:OUT_WIDTH-1]) | ~(|y_reg[TW:OUT_WIDTH-1]));

            always_comb begin
                dout_next = y_reg[OUT_WIDTH-1:0];
                sat_next  = 1'b0;
                if (ovf) begin
                    sat_next  = 1'b1;
                    dout_next = y_reg[TW] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                          : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_reg    <= '0;
                    dout_reg <= '0;
                    sat_reg  <= 1'b0;
                end else if (en) begin
                    y_reg <= y_next;
                    if (s1_valid_reg) begin
                        dout_reg <= dout_next;
                        sat_reg  <= sat_next;
                    end
                end
            end

            assign m_data[gi*OUT_WIDTH +: OUT_WIDTH] = dout_reg;
            assign m_sat[gi]                         = sat_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            m_valid_reg  <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= s_valid;
            m_valid_reg  <= s1_valid_reg;
        end
    end

    logic [CW-1:0]            pop;
    logic [CW-1:0]            sum;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_reg;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_next;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + CW'(m_sat[i]);
        end
        sum          = CW'(sat_cnt_reg) + pop;
        sat_cnt_next = sat_cnt_reg;
        if (sat_cnt_clr) begin
            sat_cnt_next = '0;
        end else if (m_valid_reg && m_ready) begin
            sat_cnt_next = (sum > CNT_MAX) ? {SAT_CNT_WIDTH{1'b1}} : sum[SAT_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_reg <= '0;
        end else begin
            sat_cnt_reg <= sat_cnt_next;
        end
    end

    assign sat_cnt = sat_cnt_reg;

endmodule

// File: tb/tb_trs_pipe.sv
// Directed bench for trs_pipe: rounding modes, saturation, backpressure,
// counter bounds (4-bit counter instance) and mid-stream reset.
module tb_trs_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rnd_mode;
    logic        s_valid;
    logic        s_ready;
    logic [71:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  m_sat;
    logic [15:0] sat_cnt;
    logic        sat_cnt_clr;

    logic        s_ready4;
    logic        m_valid4;
    logic [31:0] m_data4;
    logic [1:0]  m_sat4;
    logic [3:0]  sat_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trs_pipe dut (
        .clk(clk), .rst_n(rst_n), .rnd_mode(rnd_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sat(m_sat), .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
    );

    trs_pipe #(.SAT_CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rnd_mode(rnd_mode),
        .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
        .m_sat(m_sat4), .sat_cnt(sat_cnt4), .sat_cnt_clr(sat_cnt_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Single isolated beat with a free-flowing sink: checks latency and result.
    task automatic run_beat(input string tag, input logic [1:0] mode,
                            input logic [35:0] a, input logic [35:0] b,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [1:0] esat);
        @(negedge clk);
        rnd_mode = mode;
        s_data   = {b, a};
        s_valid  = 1'b1;
        m_ready  = 1'b1;
        @(negedge clk);
        s_valid  = 1'b0;
        rnd_mode = 2'd0;
        chk({tag, "_lat"}, 64'(m_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(m_valid), 64'd1);
        chk({tag, "_data"}, 64'({m_sat, m_data}), 64'({esat, e1, e0}));
    endtask

    initial begin
        logic [3:0]  pat;
        logic [35:0] v;
        logic [15:0] w;
        int          tx;
        int          rx;

        rst_n       = 1'b0;
        rnd_mode    = 2'd0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b1;
        sat_cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_mdata", 64'(m_data), 64'd0);
        chk("rst_msat", 64'(m_sat), 64'd0);
        chk("rst_satcnt", 64'(sat_cnt), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;

        // Positive ties: 1.5 and 2.5
        run_beat("pos_m0", 2'd0, 36'h0_0006_0000, 36'h0_000A_0000, 16'd1, 16'd2, 2'b00);
        run_beat("pos_m1", 2'd1, 36'h0_0006_0000, 36'h0_000A_0000, 16'd2, 16'd3, 2'b00);
        run_beat("pos_m2", 2'd2, 36'h0_0006_0000, 36'h0_000A_0000, 16'd2, 16'd2, 2'b00);
        run_beat("pos_m3", 2'd3, 36'h0_0006_0000, 36'h0_000A_0000, 16'd2, 16'd3, 2'b00);

        // Negative: -1.5 exact tie and -1.5 plus sticky
        run_beat("neg_m1", 2'd1, 36'hF_FFFA_0000, 36'hF_FFFA_0001, 16'hFFFF, 16'hFFFF, 2'b00);
        run_beat("neg_m2", 2'd2, 36'hF_FFFA_0000, 36'hF_FFFA_0001, 16'hFFFE, 16'hFFFF, 2'b00);
        run_beat("neg_m3", 2'd3, 36'hF_FFFA_0000, 36'hF_FFFA_0001, 16'hFFFE, 16'hFFFF, 2'b00);

        // Rounding into the headroom bit, and the most negative input
        run_beat("sat", 2'd1, 36'h1_FFFE_0000, 36'h8_0000_0000, 16'h7FFF, 16'h8000, 2'b11);
        @(negedge clk);
        chk("sat_cnt2", 64'(sat_cnt), 64'd2);

        // Backpressure stream: 8 beats, m_ready pattern 1-0-0-1
        pat = 4'b1001;
        tx  = 0;
        rx  = 0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            m_ready  = pat[cyc % 4];
            rnd_mode = 2'd0;
            s_valid  = (tx < 8);
            v        = 36'(tx + 1);
            s_data   = {(-v) << 18, v << 18};
            #1;
            chk("bp_sready", 64'(s_ready), 64'(!(m_valid && !m_ready)));
            if (m_valid && m_ready) begin
                w = 16'(rx + 1);
                chk($sformatf("bp_data%0d", rx), 64'({m_sat, m_data}), 64'({2'b00, -w, w}));
                rx++;
            end
            if (s_valid && s_ready) tx++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("bp_rx_count", 64'(rx), 64'd8);
        chk("bp_tx_count", 64'(tx), 64'd8);
        @(negedge clk);
        @(negedge clk);
        chk("bp_no_dup", 64'(m_valid), 64'd0);

        // Clear counters, then 9 fully saturating beats back to back
        sat_cnt_clr = 1'b1;
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        chk("clr_idle4", 64'(sat_cnt4), 64'd0);
        chk("clr_idle", 64'(sat_cnt), 64'd0);
        s_data  = {36'h7_FFFF_FFFF, 36'h7_FFFF_FFFF};
        s_valid = 1'b1;
        repeat (9) @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt_stick4", 64'(sat_cnt4), 64'd15);
        chk("cnt_full", 64'(sat_cnt), 64'd18);

        // Clear coinciding with a saturating handshake
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        chk("clr_hs_valid", 64'(m_valid), 64'd1);
        sat_cnt_clr = 1'b1;
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        chk("clr_hs4", 64'(sat_cnt4), 64'd0);
        chk("clr_hs", 64'(sat_cnt), 64'd0);

        // Reset with two beats in flight (counter non-zero beforehand)
        run_beat("pre_rst", 2'd1, 36'h1_FFFE_0000, 36'h8_0000_0000, 16'h7FFF, 16'h8000, 2'b11);
        s_data  = {36'h0_0010_0000, 36'h0_0010_0000};
        s_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_cnt", 64'(sat_cnt), 64'd2);
        s_data = {36'h0_0020_0000, 36'h0_0020_0000};
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_mvalid", 64'(m_valid), 64'd0);
        chk("mid_rst_mdata", 64'(m_data), 64'd0);
        chk("mid_rst_msat", 64'(m_sat), 64'd0);
        chk("mid_rst_satcnt", 64'(sat_cnt), 64'd0);
        chk("mid_rst_sready", 64'(s_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(m_valid), 64'd0);
        run_beat("post_rst", 2'd0, 36'h0_0014_0000, 36'hF_FFEC_0000, 16'd5, 16'hFFFB, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
